// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, default frame
// constants and the parity helper that the TX block also uses.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_REARM_CYCLES = 2;

    // START has no encoding: the start bit is checked on the IDLE edge
    // and the FSM moves straight to DATA.
    typedef enum logic [2:0] {
        REARM  = 3'd0,
        IDLE   = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    // Expected parity bit for a byte. Narrower frames are passed in
    // zero-extended, and zero bits do not change the XOR.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_byte_fifo2.sv
// Two-entry valid/ready byte FIFO with a registered head.
// Ports:
//   sampling_clock, init_flag  clock, async active-low reset
//   push, push_data            write strobe and byte
//   pop_ready                  consumer ready; pop = head_valid && pop_ready
//   head_data, head_valid      head-of-FIFO byte and non-empty flag
//   overrun                    one-cycle pulse: push refused because full
module uart_byte_fifo2 #(
    parameter int W = 8
) (
    input  logic         sampling_clock,
    input  logic         init_flag,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic         overrun
);

    logic [W-1:0] head_q, tail_q;
    logic [1:0]   count;
    logic         pop;

    assign pop        = pop_ready && (count != 2'd0);
    assign head_valid = (count != 2'd0);
    assign head_data  = head_q;
    // A pop on the same edge makes room, so only push-without-pop overruns.
    assign overrun    = push && (count == 2'd2) && !pop;

    always_ff @(posedge sampling_clock or negedge init_flag) begin
        if (!init_flag) begin
            head_q <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head_q <= push_data;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: head_q <= push_data;
                        2'b10: begin
                            tail_q <= push_data;
                            count  <= 2'd2;
                        end
                        2'b01: count <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    case ({push, pop})
                        2'b11: begin
                            head_q <= tail_q;
                            tail_q <= push_data;
                        end
                        2'b01: begin
                            head_q <= tail_q;
                            count  <= 2'd1;
                        end
                        default: ; // push while full is dropped
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Re-arms the bit sampler between frames,
// checks start/parity/stop bits on each sample strobe, assembles the byte
// LSB first and queues completed bytes in a 2-entry FIFO.
// Ports:
//   sampling_clock, init_flag  clock, async active-low reset
//   sample_valid, sample_bit   mid-bit strobe and value from the sampler
//   sampler_en                 high = sampler running, low = held in stop
//   rx_data, rx_valid, rx_ready  byte stream toward the core
//   frame_err, parity_err, overrun_err, timeout_err  sticky error flags
//   err_clr                    pulse clears sticky errors (a new set wins)
//   busy                       frame in progress (DATA..STOP)
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = UART_DATA_BITS,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int REARM_CYCLES   = UART_REARM_CYCLES
) (
    input  logic                 sampling_clock,
    input  logic                 init_flag,
    input  logic                 sample_valid,
    input  logic                 sample_bit,
    output logic                 sampler_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 timeout_err,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RA_W = ($clog2(REARM_CYCLES) < 2) ? 2 : $clog2(REARM_CYCLES);

    uart_rx_state_e       state, state_nxt;
    logic [RA_W-1:0]      rearm_cnt, rearm_nxt;
    logic [BC_W-1:0]      bit_cnt, bit_nxt;
    logic [TO_W-1:0]      to_cnt, to_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 frame_bad, bad_nxt;
    logic                 set_frame, set_par, set_to, push, fifo_overrun;
    logic [7:0]           par_data;

    assign sampler_en = (state != REARM);
    assign busy       = (state == DATA) || (state == PARITY) || (state == STOP);

    always_comb begin
        state_nxt = state;
        rearm_nxt = rearm_cnt;
        bit_nxt   = bit_cnt;
        to_nxt    = to_cnt;
        shift_nxt = shift_reg;
        bad_nxt   = frame_bad;
        set_frame = 1'b0;
        set_par   = 1'b0;
        set_to    = 1'b0;
        push      = 1'b0;
        par_data  = '0;
        par_data[DATA_BITS-1:0] = shift_reg;

        case (state)
            REARM: begin
                if (rearm_cnt == RA_W'(REARM_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    rearm_nxt = '0;
                end else begin
                    rearm_nxt = rearm_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (sample_valid) begin
                    if (!sample_bit) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                        to_nxt    = '0;
                        bad_nxt   = 1'b0;
                    end else begin
                        set_frame = 1'b1;
                        state_nxt = REARM;
                    end
                end
            end
            DATA, PARITY, STOP: begin
                if (sample_valid) begin
                    to_nxt = '0;
                    if (state == DATA) begin
                        shift_nxt = {sample_bit, shift_reg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(DATA_BITS - 1))
                            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else if (state == PARITY) begin
                        if (sample_bit != uart_parity(par_data, PARITY_ODD != 0)) begin
                            set_par = 1'b1;
                            bad_nxt = 1'b1;
                        end
                        state_nxt = STOP;
                    end else begin
                        if (!sample_bit)
                            set_frame = 1'b1;
                        else if (!frame_bad)
                            push = 1'b1;
                        state_nxt = REARM;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This edge is the TIMEOUT_CYCLES-th idle clock.
                    set_to    = 1'b1;
                    state_nxt = REARM;
                end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = REARM;
        endcase
    end

    always_ff @(posedge sampling_clock or negedge init_flag) begin
        if (!init_flag) begin
            state     <= REARM;
            rearm_cnt <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            shift_reg <= '0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_nxt;
            rearm_cnt <= rearm_nxt;
            bit_cnt   <= bit_nxt;
            to_cnt    <= to_nxt;
            shift_reg <= shift_nxt;
            frame_bad <= bad_nxt;
        end
    end

    // Sticky errors: the clear is applied first so a same-cycle set wins.
    always_ff @(posedge sampling_clock or negedge init_flag) begin
        if (!init_flag) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_err   <= (frame_err   && !err_clr) || set_frame;
            parity_err  <= (parity_err  && !err_clr) || set_par;
            overrun_err <= (overrun_err && !err_clr) || fifo_overrun;
            timeout_err <= (timeout_err && !err_clr) || set_to;
        end
    end

    uart_byte_fifo2 #(.W(DATA_BITS)) u_fifo (
        .sampling_clock (sampling_clock),
        .init_flag      (init_flag),
        .push           (push),
        .push_data      (shift_reg),
        .pop_ready      (rx_ready),
        .head_data      (rx_data),
        .head_valid     (rx_valid),
        .overrun        (fifo_overrun)
    );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam int TO_A = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: no parity. Instance B: even parity.
    logic       sv_a = 0, sb_a = 0, rdy_a = 1, clr_a = 0;
    logic       en_a, vld_a, fe_a, pe_a, oe_a, te_a, busy_a;
    logic [7:0] data_a;
    logic       sv_b = 0, sb_b = 0, rdy_b = 1, clr_b = 0;
    logic       en_b, vld_b, fe_b, pe_b, oe_b, te_b, busy_b;
    logic [7:0] data_b;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                         .TIMEOUT_CYCLES(TO_A), .REARM_CYCLES(2)) dut_a (
        .sampling_clock(clk), .init_flag(rst_n),
        .sample_valid(sv_a), .sample_bit(sb_a), .sampler_en(en_a),
        .rx_data(data_a), .rx_valid(vld_a), .rx_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun_err(oe_a),
        .timeout_err(te_a), .err_clr(clr_a), .busy(busy_a));

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                         .TIMEOUT_CYCLES(200), .REARM_CYCLES(2)) dut_b (
        .sampling_clock(clk), .init_flag(rst_n),
        .sample_valid(sv_b), .sample_bit(sb_b), .sampler_en(en_b),
        .rx_data(data_b), .rx_valid(vld_b), .rx_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun_err(oe_b),
        .timeout_err(te_b), .err_clr(clr_b), .busy(busy_b));

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitors: every accepted byte must match the queue head.
    always @(negedge clk) begin
        if (rst_n && vld_a && rdy_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_byte", {24'd0, data_a}, 32'hFFFF_FFFF);
            else chk("a_rx_data", {24'd0, data_a}, {24'd0, exp_a.pop_front()});
        end
        if (rst_n && vld_b && rdy_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_byte", {24'd0, data_b}, 32'hFFFF_FFFF);
            else chk("b_rx_data", {24'd0, data_b}, {24'd0, exp_b.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input int which, input logic v, input logic b);
        if (which == 0) begin sv_a = v; sb_a = b; end
        else begin sv_b = v; sb_b = b; end
    endtask

    // Send n bits (bit 0 first) with one strobe every 10 clocks. Returns
    // 1 ns after the edge that captured the last strobe.
    task automatic send_bits(input int which, input logic [10:0] bits, input int n);
        logic en;
        en = (which == 0) ? en_a : en_b;
        for (int k = 0; k < 30 && !en; k++) begin
            cyc(1);
            en = (which == 0) ? en_a : en_b;
        end
        chk("sampler_en_wait", {31'd0, en}, 32'd1);
        for (int i = 0; i < n; i++) begin
            drv(which, 1'b1, bits[i]);
            cyc(1);
            drv(which, 1'b0, 1'b0);
            if (i != n - 1) cyc(9);
        end
    endtask

    task automatic clear_errs(input int which);
        if (which == 0) clr_a = 1; else clr_b = 1;
        cyc(1);
        clr_a = 0;
        clr_b = 0;
    endtask

    initial begin
        #3;
        // Reset state, sampled while reset is asserted.
        chk("rst_sampler_en", {31'd0, en_a}, 0);
        chk("rst_rx_valid", {31'd0, vld_a}, 0);
        chk("rst_rx_data", {24'd0, data_a}, 0);
        chk("rst_errs", {28'd0, fe_a, pe_a, oe_a, te_a}, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        #4 rst_n = 1;
        cyc(1);
        chk("rearm_after_rst_1", {31'd0, en_a}, 0);
        cyc(1);
        chk("rearm_after_rst_2", {31'd0, en_a}, 1);

        // Clean byte 0x4A.
        exp_a.push_back(8'h4A);
        send_bits(0, {1'b1, 8'h4A, 1'b0}, 10);
        chk("clean_rx_valid", {31'd0, vld_a}, 1);
        chk("clean_sampler_en_0", {31'd0, en_a}, 0);
        chk("clean_errs", {28'd0, fe_a, pe_a, oe_a, te_a}, 0);
        cyc(1);
        chk("clean_rx_valid_pulse", {31'd0, vld_a}, 0);
        chk("clean_sampler_en_1", {31'd0, en_a}, 0);
        cyc(1);
        chk("clean_sampler_en_2", {31'd0, en_a}, 1);

        // Bad stop bit.
        send_bits(0, {1'b0, 8'h4A, 1'b0}, 10);
        chk("badstop_no_push", {31'd0, vld_a}, 0);
        chk("badstop_frame_err", {31'd0, fe_a}, 1);
        cyc(3);
        chk("badstop_frame_err_sticky", {31'd0, fe_a}, 1);
        clear_errs(0);
        chk("badstop_frame_err_clr", {31'd0, fe_a}, 0);

        // Even parity on instance B.
        send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        chk("par_bad_err", {31'd0, pe_b}, 1);
        chk("par_bad_no_push", {31'd0, vld_b}, 0);
        clear_errs(1);
        exp_b.push_back(8'h03);
        send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
        chk("par_good_valid", {31'd0, vld_b}, 1);
        chk("par_good_err", {31'd0, pe_b}, 0);
        cyc(2);

        // Overrun: third byte is dropped.
        rdy_a = 0;
        exp_a.push_back(8'h11);
        exp_a.push_back(8'h22);
        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        chk("ovr_none_yet", {31'd0, oe_a}, 0);
        send_bits(0, {1'b1, 8'h33, 1'b0}, 10);
        cyc(1);
        chk("ovr_err", {31'd0, oe_a}, 1);
        chk("ovr_head", {24'd0, data_a}, 32'h11);
        chk("ovr_valid", {31'd0, vld_a}, 1);
        rdy_a = 1;
        cyc(1);
        chk("ovr_second_head", {24'd0, data_a}, 32'h22);
        chk("ovr_second_valid", {31'd0, vld_a}, 1);
        cyc(1);
        chk("ovr_drained", {31'd0, vld_a}, 0);
        clear_errs(0);

        // Timeout after start + 3 data bits.
        send_bits(0, {7'd0, 4'b0100}, 4);
        cyc(TO_A - 1);
        chk("to_not_yet", {31'd0, te_a}, 0);
        chk("to_busy", {31'd0, busy_a}, 1);
        cyc(1);
        chk("to_err", {31'd0, te_a}, 1);
        chk("to_rearm", {31'd0, en_a}, 0);
        chk("to_busy_low", {31'd0, busy_a}, 0);
        chk("to_no_push", {31'd0, vld_a}, 0);
        clear_errs(0);
        exp_a.push_back(8'hA5);
        send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
        chk("to_next_valid", {31'd0, vld_a}, 1);
        cyc(2);

        // Async reset mid-DATA with a byte held and an error set.
        rdy_a = 0;
        send_bits(0, {1'b0, 8'h5C, 1'b0}, 10);
        send_bits(0, {1'b1, 8'h5C, 1'b0}, 10);
        chk("ar_pre_valid", {31'd0, vld_a}, 1);
        chk("ar_pre_frame_err", {31'd0, fe_a}, 1);
        send_bits(0, {8'd0, 3'b010}, 3);
        chk("ar_pre_busy", {31'd0, busy_a}, 1);
        #3 rst_n = 0;
        #1;
        chk("ar_busy", {31'd0, busy_a}, 0);
        chk("ar_sampler_en", {31'd0, en_a}, 0);
        chk("ar_valid", {31'd0, vld_a}, 0);
        chk("ar_data", {24'd0, data_a}, 0);
        chk("ar_errs", {28'd0, fe_a, pe_a, oe_a, te_a}, 0);
        #2 rst_n = 1;
        cyc(1);
        chk("ar_rearm_1", {31'd0, en_a}, 0);
        cyc(1);
        chk("ar_rearm_2", {31'd0, en_a}, 1);
        chk("ar_fifo_empty", {31'd0, vld_a}, 0);
        rdy_a = 1;
        cyc(3);

        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
